rom_arbiter: RTL and testbench
==============================

ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, ROM address width in bits.
REQ-002 Parameter DATA_W, default 32, ROM data width in bits.
REQ-003 Parameter LATENCY, default IF_LATENCY from core_config_pkg, ROM read latency in clk_en cycles; legal range 1..8.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 clk_en  in  1  global pipeline enable; state advances only when high.
REQ-007 if_req  in  1  fetch port request.
REQ-008 if_addr  in  ADDR_W  fetch port address.
REQ-009 if_flush  in  1  kill all in-flight fetch reads (branch redirect).
REQ-010 if_gnt  out  1  fetch request accepted this cycle.
REQ-011 if_rvalid  out  1  fetch read data valid on rdata.
REQ-012 ls_req  in  1  load port request.
REQ-013 ls_addr  in  ADDR_W  load port address.
REQ-014 ls_gnt  out  1  load request accepted this cycle.
REQ-015 ls_rvalid  out  1  load read data valid on rdata.
REQ-016 rdata  out  DATA_W  read data shared by both ports, copied from rom_rdata.
REQ-017 rom_en  out  1  ROM read strobe.
REQ-018 rom_addr  out  ADDR_W  ROM address.
REQ-019 rom_rdata  in  DATA_W  ROM data, valid LATENCY clk_en cycles after rom_en.
REQ-020 busy  out  1  at least one read is in flight.

Function
REQ-021 Grants SHALL be combinational: at most one of if_gnt and ls_gnt is high per cycle, and neither is high when clk_en=0.
REQ-022 if_gnt SHALL be 0 in any cycle where if_flush=1, even if if_req=1.
REQ-023 Without ROM_ARB_RR_EN, contention SHALL be resolved by fixed priority: ls_req wins over if_req.
REQ-024 rom_en SHALL equal if_gnt|ls_gnt, and rom_addr SHALL be the granted port's address.
REQ-025 When no grant is given, rom_addr SHALL hold its last granted value so the ROM input does not toggle.
REQ-026 Each grant SHALL push a tag {valid=1, owner, kill=0} into a LATENCY-deep tag shift register; non-grant clk_en cycles SHALL push valid=0.
REQ-027 The tag shift register SHALL shift only when clk_en=1 and SHALL hold when clk_en=0.
REQ-028 if_flush=1 with clk_en=1 SHALL set kill on every in-flight tag with owner=IF, including the tag shifting in that cycle.
REQ-029 if_rvalid SHALL be high when the last tag stage is valid, owner=IF, kill=0 and clk_en=1; ls_rvalid follows the same rule with owner=LS, ignoring kill.
REQ-030 rdata SHALL equal rom_rdata, unregistered.
REQ-031 Killed responses SHALL assert neither rvalid output.
REQ-032 busy SHALL be the OR of the valid bits of all tag stages.
REQ-033 A grant issued in the same cycle a response retires SHALL be supported, giving full throughput of one read per clk_en cycle.

Reset
REQ-034 rst_n=0 SHALL asynchronously clear every tag stage (valid, owner, kill), rom_addr and the round-robin pointer.
REQ-035 During reset, all *_rvalid outputs and busy SHALL be 0.
REQ-036 Reset asserted mid-operation SHALL discard all in-flight reads; no rvalid SHALL be produced for them after release.

Configuration
REQ-037 ROM_ARB_RR_EN defined: contention SHALL be resolved round-robin using a 1-bit last-granted pointer, reset to IF, so LS wins the first contention; the pointer updates on every grant.
REQ-038 ROM_ARB_RR_EN undefined: fixed priority per REQ-023 applies and no pointer register exists.

Verification
REQ-039 LATENCY=2, fixed priority; if_req on cycle 0 with if_addr=0x100 -> rom_en=1 and rom_addr=0x100 on cycle 0; if_rvalid=1 on cycle 2 with rdata=ROM[0x100].
REQ-040 if_req and ls_req both high for 4 cycles -> fixed priority: ls_gnt=1 all 4 cycles; RR_EN: grants alternate LS, IF, LS, IF.
REQ-041 IF reads granted on cycles 0 and 1, if_flush on cycle 1 -> no if_rvalid on cycles 2-3, and if_gnt=0 on cycle 1.
REQ-042 LS read on cycle 0 with if_flush on cycle 1 -> ls_rvalid=1 on cycle 2 (not killed).
REQ-043 Grant on cycle 0 with clk_en=0 on cycles 1-3 -> tags frozen, no rvalid while clk_en=0; rvalid on the second clk_en=1 cycle after the grant.
REQ-044 rst_n pulsed low on cycle 1 with 2 reads in flight -> busy=0 and no rvalid after release; the first new grant after release returns normally.

Source files
------------

// File: rtl/rom_arbiter.sv
// Two-port (fetch/load) arbiter in front of a fixed-latency ROM with flushable fetch responses.
// Optional round-robin arbitration is enabled with ROM_ARB_RR_EN; default is load-over-fetch priority.
package core_config_pkg;
  localparam int IF_LATENCY = 2;
endpackage

module rom_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = core_config_pkg::IF_LATENCY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  input  logic              ls_req,
  input  logic [ADDR_W-1:0] ls_addr,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_rdata,
  output logic              busy
);

  // owner: 0 = fetch, 1 = load
  typedef struct packed {
    logic valid;
    logic owner;
    logic kill;
  } tag_t;

  tag_t              tags     [LATENCY];
  tag_t              tags_nxt [LATENCY];
  logic [ADDR_W-1:0] addr_q;
  logic              if_ok;
  logic              ls_ok;
  logic              ls_wins;

  assign if_ok = clk_en & if_req & ~if_flush;
  assign ls_ok = clk_en & ls_req;

`ifdef ROM_ARB_RR_EN
  logic last_ls;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_ls <= 1'b0;
    end else if (if_gnt || ls_gnt) begin
      last_ls <= ls_gnt;
    end
  end

  assign ls_wins = ~last_ls;
`else
  assign ls_wins = 1'b1;
`endif

  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (if_ok && ls_ok) begin
      ls_gnt = ls_wins;
      if_gnt = ~ls_wins;
    end else begin
      ls_gnt = ls_ok;
      if_gnt = if_ok;
    end
  end

  assign rom_en   = if_gnt | ls_gnt;
  assign rom_addr = ls_gnt ? ls_addr : (if_gnt ? if_addr : addr_q);

  // Holding the last granted address keeps the ROM address bus quiet between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else if (rom_en) begin
      addr_q <= rom_addr;
    end
  end

  always_comb begin
    tags_nxt[0] = '{valid: rom_en, owner: ls_gnt, kill: 1'b0};
    for (int i = 1; i < LATENCY; i++) begin
      tags_nxt[i]      = tags[i-1];
      tags_nxt[i].kill = tags[i-1].kill | (if_flush & tags[i-1].valid & ~tags[i-1].owner);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        tags[i] <= '0;
      end
    end else if (clk_en) begin
      for (int i = 0; i < LATENCY; i++) begin
        tags[i] <= tags_nxt[i];
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      busy = busy | tags[i].valid;
    end
  end

  assign if_rvalid = clk_en & tags[LATENCY-1].valid & ~tags[LATENCY-1].owner & ~tags[LATENCY-1].kill;
  assign ls_rvalid = clk_en & tags[LATENCY-1].valid &  tags[LATENCY-1].owner;
  assign rdata     = rom_rdata;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: directed scenarios plus random traffic against a read-list reference model.
module tb_rom_arbiter;
  localparam int LAT  = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int HMAX = 4096;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clk_en;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic          if_gnt;
  logic          if_rvalid;
  logic          ls_req;
  logic [AW-1:0] ls_addr;
  logic          ls_gnt;
  logic          ls_rvalid;
  logic [DW-1:0] rdata;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_rdata;
  logic          busy;

  rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
    .rdata(rdata), .rom_en(rom_en), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one record per clk_en cycle index since the last reset.
  int            n;
  logic          iss_v   [HMAX];
  logic          iss_ls  [HMAX];
  logic [AW-1:0] iss_addr[HMAX];
  logic          fl_at   [HMAX];
  logic          romv    [HMAX];
  logic [AW-1:0] roma    [HMAX];
  logic [AW-1:0] last_addr;
  logic          last_ls;

  logic          obs_ifg, obs_lsg, obs_en, obs_ifv, obs_lsv, obs_busy;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_rdata;

  function automatic logic [DW-1:0] romf(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    n         = 0;
    last_addr = '0;
    last_ls   = 1'b0;
    for (int i = 0; i < HMAX; i++) begin
      iss_v[i] = 1'b0; iss_ls[i] = 1'b0; iss_addr[i] = '0;
      fl_at[i] = 1'b0; romv[i]   = 1'b0; roma[i]     = '0;
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic ce, input logic ireq, input logic [AW-1:0] iaddr,
                      input logic iflush, input logic lreq, input logic [AW-1:0] laddr);
    logic e_ifg, e_lsg, e_ifv, e_lsv, e_busy, killed;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_rdata;
    int r;
    clk_en = ce; if_req = ireq; if_addr = iaddr; if_flush = iflush;
    ls_req = lreq; ls_addr = laddr;
    if (n >= LAT && romv[n-LAT]) rom_rdata = romf(roma[n-LAT]);
    else rom_rdata = 32'hDEAD_0000 | n;
    #1;
    e_ifg = 1'b0; e_lsg = 1'b0;
    if (ce) begin
      if (lreq && ireq && !iflush) begin
`ifdef ROM_ARB_RR_EN
        e_lsg = !last_ls; e_ifg = last_ls;
`else
        e_lsg = 1'b1;
`endif
      end else begin
        e_lsg = lreq; e_ifg = ireq && !iflush;
      end
    end
    e_addr = e_lsg ? laddr : (e_ifg ? iaddr : last_addr);
    e_ifv = 1'b0; e_lsv = 1'b0; e_rdata = '0;
    r = n - LAT;
    if (ce && r >= 0 && iss_v[r]) begin
      e_rdata = romf(iss_addr[r]);
      if (iss_ls[r]) e_lsv = 1'b1;
      else begin
        killed = 1'b0;
        for (int j = r + 1; j < n; j++) killed |= fl_at[j];
        e_ifv = !killed;
      end
    end
    e_busy = 1'b0;
    for (int i = (n > LAT ? n - LAT : 0); i < n; i++) e_busy |= iss_v[i];
    obs_ifg = if_gnt; obs_lsg = ls_gnt; obs_en = rom_en; obs_addr = rom_addr;
    obs_ifv = if_rvalid; obs_lsv = ls_rvalid; obs_busy = busy; obs_rdata = rdata;
    chk("if_gnt", {31'd0, if_gnt}, {31'd0, e_ifg});
    chk("ls_gnt", {31'd0, ls_gnt}, {31'd0, e_lsg});
    chk("rom_en", {31'd0, rom_en}, {31'd0, e_ifg | e_lsg});
    chk("rom_addr", rom_addr, e_addr);
    chk("if_rvalid", {31'd0, if_rvalid}, {31'd0, e_ifv});
    chk("ls_rvalid", {31'd0, ls_rvalid}, {31'd0, e_lsv});
    chk("busy", {31'd0, busy}, {31'd0, e_busy});
    if (e_ifv || e_lsv) chk("rdata", rdata, e_rdata);
    if (ce) begin
      iss_v[n] = e_ifg | e_lsg; iss_ls[n] = e_lsg; iss_addr[n] = e_addr;
      fl_at[n] = iflush; romv[n] = rom_en; roma[n] = rom_addr;
      if (e_ifg | e_lsg) begin
        last_addr = e_addr;
        last_ls   = e_lsg;
      end
      n++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset(input logic ce);
    rst_n = 1'b0; clk_en = ce; if_req = 1'b0; ls_req = 1'b0; if_flush = 1'b0;
    #1;
    chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("rst_ls_rvalid", {31'd0, ls_rvalid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rom_addr", rom_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
  endtask

  initial begin
    rst_n = 1'b1; clk_en = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    ls_req = 1'b0; ls_addr = '0; rom_rdata = '0;
    clear_model();
    @(negedge clk);
    do_reset(1'b1);

    // Single fetch with latency 2
    step(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, '0);
    chk("d039_rom_en", {31'd0, obs_en}, 32'd1);
    chk("d039_rom_addr", obs_addr, 32'h100);
    idle(1);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    chk("d039_if_rvalid", {31'd0, obs_ifv}, 32'd1);
    chk("d039_rdata", obs_rdata, romf(32'h100));

    // Four cycles of contention
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 32'h1000 + k, 1'b0, 1'b1, 32'h2000 + k);
`ifdef ROM_ARB_RR_EN
      chk("d040_ls_gnt", {31'd0, obs_lsg}, (k % 2 == 0) ? 32'd1 : 32'd0);
`else
      chk("d040_ls_gnt", {31'd0, obs_lsg}, 32'd1);
`endif
    end
    idle(LAT);

    // Fetch flush kills in-flight fetch and blocks the flush-cycle grant
    step(1'b1, 1'b1, 32'h200, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 32'h204, 1'b1, 1'b0, '0);
    chk("d041_if_gnt_flush", {31'd0, obs_ifg}, 32'd0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    chk("d041_if_rvalid_c2", {31'd0, obs_ifv}, 32'd0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    chk("d041_if_rvalid_c3", {31'd0, obs_ifv}, 32'd0);

    // Load responses survive a fetch flush
    step(1'b1, 1'b0, '0, 1'b0, 1'b1, 32'h300);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    chk("d042_ls_rvalid", {31'd0, obs_lsv}, 32'd1);
    chk("d042_rdata", obs_rdata, romf(32'h300));

    // Tags freeze while clk_en is low
    step(1'b1, 1'b1, 32'h400, 1'b0, 1'b0, '0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 32'h404, 1'b0, 1'b1, 32'h408);
      chk("d043_no_rvalid", {31'd0, obs_ifv | obs_lsv}, 32'd0);
      chk("d043_busy", {31'd0, obs_busy}, 32'd1);
    end
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    chk("d043_if_rvalid_1st", {31'd0, obs_ifv}, 32'd0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    chk("d043_if_rvalid_2nd", {31'd0, obs_ifv}, 32'd1);

    // Reset with reads in flight
    step(1'b1, 1'b1, 32'h500, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b1, 32'h504);
    do_reset(1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
      chk("d044_no_rvalid", {31'd0, obs_ifv | obs_lsv}, 32'd0);
      chk("d044_busy", {31'd0, obs_busy}, 32'd0);
    end
    step(1'b1, 1'b1, 32'h600, 1'b0, 1'b0, '0);
    idle(1);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    chk("d044_if_rvalid_new", {31'd0, obs_ifv}, 32'd1);
    chk("d044_rdata_new", obs_rdata, romf(32'h600));

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 99) == 0) do_reset(1'($urandom_range(0, 1)));
      else step(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)), $urandom,
                1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
